// File: rtl/alu_ctrl.sv
// UART ALU packet controller: parses opcode/rsvd/len header, then echoes, add-reduces or xor-reduces the payload.
// Responses start one cycle after the last payload byte; rx stalls while tx is backpressured in echo/response states.
module alu_ctrl #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] rx_data_i,
    input  logic                  rx_valid_i,
    output logic                  rx_ready_o,
    output logic [DATA_WIDTH-1:0] tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam logic [7:0] OP_ECHO  = 8'hEC;
    localparam logic [7:0] OP_ADD   = 8'h00;
    localparam logic [7:0] OP_XOR   = 8'h01;
    localparam logic [7:0] ERR_BYTE = 8'hEE;

    typedef enum logic [3:0] {
        S_OPCODE,
        S_RSVD,
        S_LEN_LO,
        S_LEN_HI,
        S_ECHO,
        S_ACCUM,
        S_RESP,
        S_DRAIN,
        S_ERR
    } state_t;

    state_t                  state_q;
    state_t                  state_n;
    state_t                  hdr_next;
    logic [7:0]              opcode_q;
    logic [7:0]              len_lo_q;
    logic [15:0]             remain_q;
    logic [31:0]             acc_q;
    logic [23:0]             word_q;
    logic [1:0]              byte_cnt_q;
    logic [1:0]              resp_cnt_q;
    logic [31:0]             idle_cnt_q;
    logic [DATA_WIDTH-1:0]   tx_dat_q;
    logic                    tx_vld_q;
    logic                    err_q;

    logic                    rx_hs;
    logic                    tx_hs;
    logic                    timed;
    logic                    timeout;
    logic [15:0]             len_full;
    logic [15:0]             payload;
    logic                    op_legal;
    logic [31:0]             full_word;
    logic [7:0]              resp_byte;

    assign rx_hs      = rx_valid_i && rx_ready_o;
    assign tx_hs      = tx_vld_q && tx_ready_i;
    assign tx_valid_o = tx_vld_q;
    assign tx_data_o  = tx_dat_q;
    assign err_o      = err_q;

    // Idle time only counts while waiting on the host, never on tx backpressure.
    assign timed = (state_q == S_RSVD) || (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                   (state_q == S_ACCUM) || (state_q == S_DRAIN) ||
                   ((state_q == S_ECHO) && !tx_vld_q);
    assign timeout = (TIMEOUT_CYCLES != 0) && timed && !rx_hs &&
                     (idle_cnt_q == TIMEOUT_CYCLES - 1);

    assign len_full  = {rx_data_i, len_lo_q};
    assign payload   = len_full - 16'd4;
    assign op_legal  = (opcode_q == OP_ECHO) || (opcode_q == OP_ADD) || (opcode_q == OP_XOR);
    assign full_word = {rx_data_i, word_q};

    always_comb begin
        hdr_next = S_ERR;
        if (len_full < 16'd4) begin
            hdr_next = S_ERR;
        end else if (!op_legal || ((opcode_q != OP_ECHO) && (payload[1:0] != 2'b00))) begin
            hdr_next = (payload != 16'd0) ? S_DRAIN : S_ERR;
        end else if (opcode_q == OP_ECHO) begin
            hdr_next = (payload != 16'd0) ? S_ECHO : S_OPCODE;
        end else begin
            hdr_next = (payload != 16'd0) ? S_ACCUM : S_RESP;
        end
    end

    always_comb begin
        resp_byte = acc_q[31:24];
        case (resp_cnt_q)
            2'd0:    resp_byte = acc_q[15:8];
            2'd1:    resp_byte = acc_q[23:16];
            default: resp_byte = acc_q[31:24];
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_OPCODE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            S_OPCODE: if (rx_hs) state_n = S_RSVD;
            S_RSVD:   if (rx_hs) state_n = S_LEN_LO;
            S_LEN_LO: if (rx_hs) state_n = S_LEN_HI;
            S_LEN_HI: if (rx_hs) state_n = hdr_next;
            S_ECHO:   if (tx_hs && (remain_q == 16'd0)) state_n = S_OPCODE;
            S_ACCUM:  if (rx_hs && (remain_q == 16'd1)) state_n = S_RESP;
            S_RESP:   if (tx_hs && (resp_cnt_q == 2'd3)) state_n = S_OPCODE;
            S_DRAIN:  if (rx_hs && (remain_q == 16'd1)) state_n = S_ERR;
            S_ERR:    if (tx_hs) state_n = S_OPCODE;
            default:  state_n = S_OPCODE;
        endcase
        if (timeout) begin
            state_n = S_OPCODE;
        end
    end

    always_comb begin
        rx_ready_o = 1'b0;
        case (state_q)
            S_OPCODE, S_RSVD, S_LEN_LO, S_LEN_HI, S_ACCUM, S_DRAIN: rx_ready_o = 1'b1;
            S_ECHO:  rx_ready_o = !tx_vld_q && (remain_q != 16'd0);
            default: rx_ready_o = 1'b0;
        endcase
        busy_o = (state_q != S_OPCODE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            opcode_q   <= '0;
            len_lo_q   <= '0;
            remain_q   <= '0;
            acc_q      <= '0;
            word_q     <= '0;
            byte_cnt_q <= '0;
            resp_cnt_q <= '0;
            idle_cnt_q <= '0;
            tx_dat_q   <= '0;
            tx_vld_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q      <= timeout || ((state_n == S_ERR) && (state_q != S_ERR));
            idle_cnt_q <= (timed && !rx_hs && !timeout) ? idle_cnt_q + 32'd1 : 32'd0;
            if (tx_hs) begin
                tx_vld_q <= 1'b0;
            end
            case (state_q)
                S_OPCODE: if (rx_hs) opcode_q <= rx_data_i;
                S_LEN_LO: if (rx_hs) len_lo_q <= rx_data_i;
                S_LEN_HI: begin
                    if (rx_hs) begin
                        remain_q   <= payload;
                        acc_q      <= '0;
                        byte_cnt_q <= '0;
                        resp_cnt_q <= '0;
                    end
                end
                S_ECHO: begin
                    if (rx_hs) begin
                        tx_dat_q <= rx_data_i;
                        tx_vld_q <= 1'b1;
                        remain_q <= remain_q - 16'd1;
                    end
                end
                S_ACCUM: begin
                    if (rx_hs) begin
                        remain_q   <= remain_q - 16'd1;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        case (byte_cnt_q)
                            2'd0: word_q[7:0]   <= rx_data_i;
                            2'd1: word_q[15:8]  <= rx_data_i;
                            2'd2: word_q[23:16] <= rx_data_i;
                            default: acc_q <= (opcode_q == OP_ADD) ? acc_q + full_word
                                                                   : acc_q ^ full_word;
                        endcase
                    end
                end
                S_RESP: begin
                    // tx_vld stays high between the four result bytes, so low means entry cycle.
                    if (!tx_vld_q) begin
                        tx_vld_q <= 1'b1;
                        tx_dat_q <= acc_q[7:0];
                    end else if (tx_hs) begin
                        if (resp_cnt_q == 2'd3) begin
                            resp_cnt_q <= 2'd0;
                        end else begin
                            resp_cnt_q <= resp_cnt_q + 2'd1;
                            tx_vld_q   <= 1'b1;
                            tx_dat_q   <= resp_byte;
                        end
                    end
                end
                S_DRAIN: if (rx_hs) remain_q <= remain_q - 16'd1;
                S_ERR: begin
                    if (!tx_vld_q) begin
                        tx_vld_q <= 1'b1;
                        tx_dat_q <= ERR_BYTE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
